crossing_phase_meter: RTL

Downstream consumer of two zero-crossing detectors: one on the reference channel, one on the measured channel. Pairs each measured crossing with the reference crossing that precedes it and computes the delay between them and the reference period. Both values are averaged over 2^AVG_LOG2 reference periods. Output feeds the phase-readout/ethernet framing stage as a (period, delay) pair with a one-cycle valid strobe.

---
 rtl/crossing_phase_meter_pkg.sv | 6 +
 rtl/crossing_phase_meter_window_avg.sv | 34 +++
 rtl/crossing_phase_meter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/crossing_phase_meter_pkg.sv
// crossing_phase_pkg: shared states and constants for the crossing phase meter
package crossing_phase_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_FIRST, TRACK} state_e;
  localparam int DEFAULT_TIME_W = 32;
  localparam logic [15:0] MISS_MAX = 16'hFFFF;
endpackage

// File: rtl/crossing_phase_meter_window_avg.sv
// window_avg: accumulates 2^LOG2 samples and presents their truncated mean on the completing add
module window_avg #(
  parameter int W    = 32,
  parameter int LOG2 = 3
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         add_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] avg_o,
  output logic         tc_o
);
  localparam int SW = W + LOG2;
  localparam int CW = LOG2 + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2) - 1);
  logic [SW-1:0] r_sum;
  logic [SW-1:0] w_next;
  logic [CW-1:0] r_cnt;
  // The mean includes the sample being added so the top can register it in the same cycle.
  assign w_next = r_sum + (add_i ? SW'(val_i) : '0);
  assign avg_o  = w_next[SW-1:LOG2];
  assign tc_o   = add_i && r_cnt == LAST;
  // Sum and sample count; a full window restarts from zero.
  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i || tc_o) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (add_i) begin
      r_sum <= w_next;
      r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/crossing_phase_meter.sv
// crossing_phase_meter: pairs measured crossings with the preceding reference crossing and averages period/delay
module crossing_phase_meter
  import crossing_phase_pkg::*;
#(
  parameter int                 TIME_W   = DEFAULT_TIME_W,
  parameter int                 AVG_LOG2 = 3,
  parameter logic [TIME_W-1:0]  TIMEOUT  = TIME_W'(1_000_000)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [TIME_W-1:0] current_time_i,
  input  logic              ref_pulse_i,
  input  logic [TIME_W-1:0] ref_time_i,
  input  logic              sig_pulse_i,
  input  logic [TIME_W-1:0] sig_time_i,
  output logic [TIME_W-1:0] period_o,
  output logic [TIME_W-1:0] delay_o,
  output logic              valid_o,
  output logic              locked_o,
  output logic [15:0]       miss_cnt_o
);
  state_e            r_state;
  state_e            w_next_state;
  logic [TIME_W-1:0] r_last_ref;
  logic [TIME_W-1:0] r_cur_delay;
  logic              r_have_sig;
  logic [TIME_W-1:0] r_period;
  logic [TIME_W-1:0] r_delay;
  logic              r_valid;
  logic              r_locked;
  logic [15:0]       r_miss;
  logic [TIME_W-1:0] w_elapsed;
  logic [TIME_W-1:0] w_sig_delay;
  logic [TIME_W-1:0] w_cur_period;
  logic [TIME_W-1:0] w_cur_delay;
  logic              w_timeout;
  logic              w_good;
  logic              w_clr;
  logic              w_load_ref;
  logic              w_close;
  logic              w_latch_sig;
  logic              w_add;
  logic              w_miss;
  logic              w_drop;
  logic [TIME_W-1:0] w_period_avg;
  logic [TIME_W-1:0] w_delay_avg;
  logic              w_tc_p;
  logic              w_tc_d;
  logic              w_tc;
  assign w_elapsed    = current_time_i - r_last_ref;
  assign w_sig_delay  = sig_time_i - r_last_ref;
  assign w_cur_period = ref_time_i - r_last_ref;
  assign w_timeout    = w_elapsed > TIMEOUT;
  // A sig strobe in the closing cycle counts toward the closing period, measured from the old reference.
  assign w_cur_delay  = r_have_sig ? r_cur_delay : w_sig_delay;
  assign w_good       = (r_have_sig || sig_pulse_i) && w_cur_delay < w_cur_period && w_cur_period != '0;
  assign w_tc         = w_tc_p & w_tc_d;
  window_avg #(.W(TIME_W), .LOG2(AVG_LOG2)) u_period_avg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (w_clr),
    .add_i   (w_add),
    .val_i   (w_cur_period),
    .avg_o   (w_period_avg),
    .tc_o    (w_tc_p)
  );
  window_avg #(.W(TIME_W), .LOG2(AVG_LOG2)) u_delay_avg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (w_clr),
    .add_i   (w_add),
    .val_i   (w_cur_delay),
    .avg_o   (w_delay_avg),
    .tc_o    (w_tc_d)
  );
  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= IDLE;
    else r_state <= w_next_state;
  end
  // Next state and per-cycle actions; a timeout wins over any strobe in the same cycle.
  always_comb begin
    w_next_state = r_state;
    w_clr        = 1'b0;
    w_load_ref   = 1'b0;
    w_close      = 1'b0;
    w_latch_sig  = 1'b0;
    w_add        = 1'b0;
    w_miss       = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_clr        = 1'b1;
        w_next_state = WAIT_FIRST;
      end
      WAIT_FIRST: begin
        w_load_ref   = ref_pulse_i;
        w_next_state = ref_pulse_i ? TRACK : WAIT_FIRST;
      end
      TRACK: begin
        if (w_timeout) begin
          w_drop       = 1'b1;
          w_miss       = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_latch_sig = sig_pulse_i && !r_have_sig;
          w_close     = ref_pulse_i;
          w_add       = ref_pulse_i && w_good;
          w_miss      = ref_pulse_i && !w_good;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end
  // Reference anchor plus the first measured delay of the open period.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_last_ref  <= '0;
      r_cur_delay <= '0;
      r_have_sig  <= 1'b0;
    end else begin
      if (w_load_ref || w_close) r_last_ref <= ref_time_i;
      if (w_clr || w_close) r_have_sig <= 1'b0;
      else if (w_latch_sig) begin
        r_have_sig  <= 1'b1;
        r_cur_delay <= w_sig_delay;
      end
    end
  end
  // Published results, lock flag and saturating miss counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_period <= '0;
      r_delay  <= '0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
      r_miss   <= '0;
    end else begin
      r_valid <= w_tc;
      if (w_tc) begin
        r_period <= w_period_avg;
        r_delay  <= w_delay_avg;
        r_locked <= 1'b1;
      end else if (w_drop) r_locked <= 1'b0;
      if (w_miss && r_miss != MISS_MAX) r_miss <= r_miss + 16'd1;
    end
  end
  assign period_o   = r_period;
  assign delay_o    = r_delay;
  assign valid_o    = r_valid;
  assign locked_o   = r_locked;
  assign miss_cnt_o = r_miss;
endmodule
